// File: rtl/vram_port.sv
// CPU register window onto port 1 of the dual-port video RAM: auto-incrementing
// pointer, two-write address latch and a one-deep buffered read path.
module vram_port #(
  parameter int P_addr_bits = 12,
  parameter int P_data_bits = 8
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  input  logic                   I_cpu_cs,
  input  logic                   I_cpu_rw,
  input  logic [1:0]             I_cpu_addr,
  input  logic [P_data_bits-1:0] I_cpu_data,
  output logic [P_data_bits-1:0] O_cpu_data,
  output logic                   O_cpu_ready,
  output logic                   O_mem_clock,
  output logic [P_addr_bits-1:0] O_mem_addr,
  output logic                   O_mem_rden,
  output logic                   O_mem_wren,
  output logic [P_data_bits-1:0] O_mem_data,
  input  logic [P_data_bits-1:0] I_mem_data
);

  localparam int HI_BITS = P_addr_bits - P_data_bits;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_ADDR   = 2'd2,
    REG_DATA   = 2'd3
  } reg_sel_e;

  // RD_ISSUE: rden is on the RAM port; RD_CAPTURE: RAM data is valid this cycle.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_CAPTURE
  } rd_state_e;

  rd_state_e              rd_state;
  logic [P_addr_bits-1:0] ptr;
  logic [P_data_bits-1:0] ctrl;
  logic [P_data_bits-1:0] rbuf;
  logic                   toggle;

  logic                   busy;
  logic                   accept;
  logic [P_addr_bits-1:0] ptr_inc;
  reg_sel_e               sel;

  assign O_mem_clock = I_clock;

  assign sel     = reg_sel_e'(I_cpu_addr);
  assign busy    = (rd_state != RD_IDLE);
  // Only DATA accesses wait for the read buffer; register accesses go through.
  assign accept  = I_cpu_cs && ((sel != REG_DATA) || !busy);
  assign ptr_inc = ctrl[0] ? P_addr_bits'(32) : P_addr_bits'(1);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      rd_state    <= RD_IDLE;
      ptr         <= '0;
      ctrl        <= '0;
      rbuf        <= '0;
      toggle      <= 1'b0;
      O_cpu_data  <= '0;
      O_cpu_ready <= 1'b1;
      O_mem_addr  <= '0;
      O_mem_rden  <= 1'b0;
      O_mem_wren  <= 1'b0;
      O_mem_data  <= '0;
    end else begin
      O_mem_rden <= 1'b0;
      O_mem_wren <= 1'b0;

      case (rd_state)
        RD_ISSUE:   rd_state <= RD_CAPTURE;
        RD_CAPTURE: begin
          rbuf        <= I_mem_data;
          rd_state    <= RD_IDLE;
          O_cpu_ready <= 1'b1;
        end
        default:    rd_state <= RD_IDLE;
      endcase

      if (accept) begin
        case (sel)
          REG_CTRL: begin
            if (I_cpu_rw) O_cpu_data <= ctrl;
            else          ctrl       <= I_cpu_data;
          end
          REG_STATUS: begin
            if (I_cpu_rw) begin
              O_cpu_data <= {toggle, {(P_data_bits-2){1'b0}}, busy};
              toggle     <= 1'b0;
            end
          end
          REG_ADDR: begin
            if (I_cpu_rw) begin
              O_cpu_data <= '0;
            end else if (!toggle) begin
              ptr    <= {I_cpu_data[HI_BITS-1:0], ptr[P_data_bits-1:0]};
              toggle <= 1'b1;
            end else begin
              ptr    <= {ptr[P_addr_bits-1:P_data_bits], I_cpu_data};
              toggle <= 1'b0;
            end
          end
          REG_DATA: begin
            O_mem_addr <= ptr;
            ptr        <= ptr + ptr_inc;
            if (I_cpu_rw) begin
              // Return what the previous read fetched; this read refills rbuf.
              O_cpu_data  <= rbuf;
              O_mem_rden  <= 1'b1;
              rd_state    <= RD_ISSUE;
              O_cpu_ready <= 1'b0;
            end else begin
              O_mem_data <= I_cpu_data;
              O_mem_wren <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
